rf_port_sequencer: RTL
======================

# rf_port_sequencer

Owns all ports of the 32×64 register file: runs a two-write boot initialisation (sp, gp), then passes pipeline decode reads and writeback writes straight through, and inserts single debug read/write accesses by holding the pipeline for one cycle. It sits between the decode/writeback stages, the debug module and the register file, and is the only block driving the register file's write and read-address ports.

## Interface
- XLEN, 64, data width
- SP_INIT, 64'h0000_0000_0000_FFF0, boot value for x2
- GP_INIT, 64'h0000_0000_0000_1800, boot value for x3

- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- WB_WE, WB_ADDR, WB_DATA  in  1/5/XLEN  pipeline writeback request
- ID_RS1, ID_RS2  in  5/5  decode read addresses
- ID_RD1, ID_RD2  out  XLEN  decode read data
- DBG_REQ, DBG_WRITE, DBG_ADDR, DBG_WDATA  in  1/1/5/XLEN  debug request
- DBG_ACK, DBG_ERR  out  1/1  one-cycle completion pulse, error flag
- DBG_RDATA  out  XLEN  registered debug read data
- HOLD  out  1  freeze whole pipeline
- READY  out  1  boot sequence complete
- RF_WE, RF_WR_ADDR, RF_WR_DATA  out  1/5/XLEN  register file write port
- RF_RD_ADDR1, RF_RD_ADDR2  out  5/5  register file read addresses
- RF_RD_DATA1, RF_RD_DATA2  in  XLEN  register file asynchronous read data

## Operation
- States: INIT_SP → INIT_GP → RUN ⇄ DBG_ACC → DBG_DONE → RUN.
- INIT_SP: RF_WE=1, RF_WR_ADDR=2, RF_WR_DATA=SP_INIT; HOLD=1.
- INIT_GP: same with addr 3, GP_INIT; HOLD=1. Next state is RUN.
- RUN: READY=1, HOLD=0.
  - RF write port = WB_WE/WB_ADDR/WB_DATA.
  - RF_RD_ADDR1/2 = ID_RS1/2; ID_RD1/2 = RF_RD_DATA1/2.
  - If DBG_REQ=1: go to DBG_ACC next cycle.
- DBG_ACC: HOLD=1; WB_WE is ignored (gated off). The pipeline retains its writeback stage and replays it after HOLD falls.
  - Read (DBG_WRITE=0): RF_RD_ADDR1=DBG_ADDR; RF_RD_DATA1 is captured into DBG_RDATA at the cycle end.
  - Write (DBG_WRITE=1, DBG_ADDR≠0): RF_WE=1, RF_WR_ADDR=DBG_ADDR, RF_WR_DATA=DBG_WDATA.
  - Write to x0: no RF write; DBG_ERR is set.
- DBG_DONE: DBG_ACK=1 for exactly one cycle; DBG_ERR is valid in the same cycle and 0 otherwise; HOLD=0. Next state is RUN.
- Debug handshake:
  - DBG_REQ and its fields are held stable until DBG_ACK.
  - The requester drops DBG_REQ in the cycle after DBG_ACK.
  - DBG_REQ still high in the RUN cycle after DBG_DONE is a new request.
- DBG_REQ during INIT states is held off; it is accepted once in RUN.
- A debug read of x0 returns 0 (the register file forces x0 to zero); DBG_ERR=0.
- WB writes to x0 are passed through; the register file discards them.

## Timing
- Reset values: state INIT_SP, HOLD=1, READY=0, DBG_ACK=0, DBG_ERR=0, DBG_RDATA=0.
- RF_WE follows the state in the same cycle, so RF_WE=1 in the first cycle after reset.
- Boot: READY rises two cycles after RESET falls; x2 and x3 are valid from then on.
- Debug latency: request seen in RUN at cycle n; access in cycle n+1; DBG_ACK in cycle n+2.
- HOLD is high for exactly one cycle per debug access.
- Back-to-back debug accesses are separated by at least one RUN cycle. The pipeline therefore advances at least one cycle between holds.
- RESET mid-access: the access is aborted, DBG_ACK is not issued, and the boot sequence reruns.
- All outputs are combinational from the state register, except DBG_RDATA and DBG_ERR, which are registered.

## Configuration
- RF_WB_BYPASS_EN defined, applies in RUN only:
  - If WB_WE=1, WB_ADDR≠0 and WB_ADDR==ID_RS1, then ID_RD1=WB_DATA; same rule for ID_RS2/ID_RD2.
  - This covers same-cycle write-then-read.
- RF_WB_BYPASS_EN undefined: ID_RD1/2 = RF_RD_DATA1/2 always. Decode sees the old value in a same-cycle collision, and the hazard unit must stall.

## Test plan
- Boot: release RESET → RF writes x2=0xFFF0 then x3=0x1800; READY=1 in cycle 2; HOLD=1 in cycles 0–1.
- Debug write: in RUN, DBG_REQ=1, DBG_WRITE=1, addr 5, data 0xDEAD → HOLD=1 in cycle n+1, x5=0xDEAD, DBG_ACK=1 in cycle n+2 with DBG_ERR=0.
- Debug read under writeback: x7=0x1234, WB_WE=1 to x9 continuously, debug read x7 → DBG_RDATA=0x1234; the x9 write is suppressed during HOLD and lands after replay.
- x0 write: debug write addr 0 data 0xFF → no RF_WE; DBG_ACK with DBG_ERR=1; a later read of x0 returns 0.
- Bypass: WB_WE=1 to x4 with 0xABCD, ID_RS1=4 in the same cycle → ID_RD1=0xABCD with RF_WB_BYPASS_EN; old x4 value without it.
- RESET asserted in DBG_ACC → no DBG_ACK; boot sequence repeats; READY=0 for two cycles.

Source files
------------

// File: rtl/rf_port_sequencer_if.sv
// Bundle of every pipeline, debug and register-file signal owned by rf_port_sequencer.
// The slave modport is the sequencer; the master modport is the surrounding environment.
interface rf_port_sequencer_if #(
  parameter int XLEN = 64
);
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [XLEN-1:0] id_rd1;
  logic [XLEN-1:0] id_rd2;

  logic            dbg_req;
  logic            dbg_write;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic            dbg_ack;
  logic            dbg_err;
  logic [XLEN-1:0] dbg_rdata;

  logic            hold;
  logic            ready;

  logic            rf_we;
  logic [4:0]      rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
  logic [4:0]      rf_rd_addr1;
  logic [4:0]      rf_rd_addr2;
  logic [XLEN-1:0] rf_rd_data1;
  logic [XLEN-1:0] rf_rd_data2;

  modport slave (
    input  wb_we, wb_addr, wb_data, id_rs1, id_rs2,
    input  dbg_req, dbg_write, dbg_addr, dbg_wdata,
    input  rf_rd_data1, rf_rd_data2,
    output id_rd1, id_rd2, dbg_ack, dbg_err, dbg_rdata, hold, ready,
    output rf_we, rf_wr_addr, rf_wr_data, rf_rd_addr1, rf_rd_addr2
  );

  modport master (
    output wb_we, wb_addr, wb_data, id_rs1, id_rs2,
    output dbg_req, dbg_write, dbg_addr, dbg_wdata,
    output rf_rd_data1, rf_rd_data2,
    input  id_rd1, id_rd2, dbg_ack, dbg_err, dbg_rdata, hold, ready,
    input  rf_we, rf_wr_addr, rf_wr_data, rf_rd_addr1, rf_rd_addr2
  );
endinterface

// File: rtl/rf_port_sequencer.sv
// Register-file port owner: boots sp/gp, passes pipeline traffic, slots in one-cycle debug accesses.
// Optional macro RF_WB_BYPASS_EN forwards same-cycle writeback data to the decode read ports.
module rf_port_sequencer #(
  parameter int              XLEN    = 64,
  parameter logic [XLEN-1:0] SP_INIT = 64'h0000_0000_0000_FFF0,
  parameter logic [XLEN-1:0] GP_INIT = 64'h0000_0000_0000_1800
) (
  input logic                 clk_i,
  input logic                 rst_i,
  rf_port_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    INIT_SP  = 3'd0,
    INIT_GP  = 3'd1,
    RUN      = 3'd2,
    DBG_ACC  = 3'd3,
    DBG_DONE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            dbg_err_q, dbg_err_d;
  logic [XLEN-1:0] dbg_rdata_q;

  logic            rf_we;
  logic [4:0]      rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
  logic [4:0]      rf_rd_addr1;
  logic [4:0]      rf_rd_addr2;
  logic [XLEN-1:0] id_rd1;
  logic [XLEN-1:0] id_rd2;
  logic            hold;
  logic            ready;
  logic            dbg_ack;
  logic            dbg_capture;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT_SP;
      dbg_err_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      dbg_err_q <= dbg_err_d;
      if (dbg_capture) begin
        dbg_rdata_q <= bus.rf_rd_data1;
      end
    end
  end

  // Error is only meaningful in DBG_DONE, so it is computed from the access cycle alone.
  assign dbg_err_d   = (state_q == DBG_ACC) && bus.dbg_write && (bus.dbg_addr == 5'd0);
  assign dbg_capture = (state_q == DBG_ACC) && !bus.dbg_write;

  always_comb begin
    state_d     = state_q;
    rf_we       = 1'b0;
    rf_wr_addr  = bus.wb_addr;
    rf_wr_data  = bus.wb_data;
    rf_rd_addr1 = bus.id_rs1;
    rf_rd_addr2 = bus.id_rs2;
    id_rd1      = bus.rf_rd_data1;
    id_rd2      = bus.rf_rd_data2;
    hold        = 1'b0;
    ready       = 1'b1;
    dbg_ack     = 1'b0;
    case (state_q)
      INIT_SP: begin
        rf_we      = 1'b1;
        rf_wr_addr = 5'd2;
        rf_wr_data = SP_INIT;
        hold       = 1'b1;
        ready      = 1'b0;
        state_d    = INIT_GP;
      end
      INIT_GP: begin
        rf_we      = 1'b1;
        rf_wr_addr = 5'd3;
        rf_wr_data = GP_INIT;
        hold       = 1'b1;
        ready      = 1'b0;
        state_d    = RUN;
      end
      RUN: begin
        rf_we = bus.wb_we;
`ifdef RF_WB_BYPASS_EN
        if (bus.wb_we && (bus.wb_addr != 5'd0) && (bus.wb_addr == bus.id_rs1)) begin
          id_rd1 = bus.wb_data;
        end
        if (bus.wb_we && (bus.wb_addr != 5'd0) && (bus.wb_addr == bus.id_rs2)) begin
          id_rd2 = bus.wb_data;
        end
`endif
        if (bus.dbg_req) begin
          state_d = DBG_ACC;
        end
      end
      DBG_ACC: begin
        // Writeback is gated off here; the held pipeline replays it once HOLD drops.
        hold        = 1'b1;
        rf_rd_addr1 = bus.dbg_addr;
        if (bus.dbg_write && (bus.dbg_addr != 5'd0)) begin
          rf_we      = 1'b1;
          rf_wr_addr = bus.dbg_addr;
          rf_wr_data = bus.dbg_wdata;
        end
        state_d = DBG_DONE;
      end
      DBG_DONE: begin
        rf_we   = bus.wb_we;
        dbg_ack = 1'b1;
        state_d = RUN;
      end
      default: begin
        hold    = 1'b1;
        ready   = 1'b0;
        state_d = INIT_SP;
      end
    endcase
  end

  assign bus.rf_we       = rf_we;
  assign bus.rf_wr_addr  = rf_wr_addr;
  assign bus.rf_wr_data  = rf_wr_data;
  assign bus.rf_rd_addr1 = rf_rd_addr1;
  assign bus.rf_rd_addr2 = rf_rd_addr2;
  assign bus.id_rd1      = id_rd1;
  assign bus.id_rd2      = id_rd2;
  assign bus.hold        = hold;
  assign bus.ready       = ready;
  assign bus.dbg_ack     = dbg_ack;
  assign bus.dbg_err     = dbg_err_q;
  assign bus.dbg_rdata   = dbg_rdata_q;

endmodule
